// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: request/response handshake and data-port memory bus of the load/store unit.
interface lsu_mem_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [31:0]           mem_wr_data;
    logic [3:0]            mem_byte_en;
    logic [31:0]           mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag, resp_ready, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_tag, resp_err, mem_addr, mem_wr_en, mem_wr_data, mem_byte_en
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_tag, resp_ready, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_tag, resp_err, mem_addr, mem_wr_en, mem_wr_data, mem_byte_en
    );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: one-at-a-time RV32 load/store requester for the data port of a
// dual-port word memory with one-cycle registered read latency.
module lsu_mem_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input logic            clk,
    input logic            rst_n,
    lsu_mem_port_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t                state, state_nx;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  err_q;
    logic [31:0]           rdata_q;
    logic                  accept;
    logic                  bad_f3;
    logic                  misal;
    logic [1:0]            k;
    logic [31:0]           sh;
    logic [31:0]           ext;
    logic [3:0]            be;

    assign accept = state == IDLE && bus.req_valid;
    assign bad_f3 = bus.req_we ? bus.req_funct3 > 3'd2
                               : (bus.req_funct3 == 3'd3 || bus.req_funct3 > 3'd5);
    assign misal  = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                    (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);

    assign k   = addr_q[1:0];
    assign sh  = bus.mem_rd_data >> {k, 3'b000};
    // Bit 2 of funct3 selects the unsigned variants (BU/HU).
    assign ext = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                 f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
    assign be  = f3_q[1:0] == 2'd0 ? 4'b0001 << k :
                 f3_q[1:0] == 2'd1 ? 4'b0011 << k : 4'b1111;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                tag_q   <= bus.req_tag;
                err_q   <= bad_f3 || misal;
                rdata_q <= 32'd0;
            end
            if (state == CAPTURE) rdata_q <= ext;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.req_valid ? ((bad_f3 || misal) ? RESP : ISSUE) : IDLE;
            ISSUE:   state_nx = we_q ? RESP : CAPTURE;
            CAPTURE: state_nx = RESP;
            RESP:    state_nx = bus.resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready   = state == IDLE;
    assign bus.resp_valid  = state == RESP;
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_tag    = tag_q;
    assign bus.resp_err    = err_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_en   = state == ISSUE && we_q;
    assign bus.mem_byte_en = (state == ISSUE && we_q) ? be : 4'b0000;
    assign bus.mem_wr_data = f3_q[1:0] == 2'd0 ? {4{wdata_q[7:0]}} :
                             f3_q[1:0] == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed plus random transactions checked against a byte-addressed
// reference memory and per-transaction latency/lane expectations.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_wr_data;
    logic [31:0] mem [64] = '{default: 32'd0};
    logic [7:0]  ref_bytes [256];

    lsu_mem_port_if #(.ADDR_WIDTH(32), .TAG_WIDTH(5)) bus ();
    lsu_mem_port #(.ADDR_WIDTH(32), .TAG_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Data-port memory: byte-lane writes, registered read of the presented word.
    always @(posedge clk) begin
        if (bus.mem_wr_en)
            for (int i = 0; i < 4; i++)
                if (bus.mem_byte_en[i]) mem[bus.mem_addr[7:2]][8*i +: 8] <= bus.mem_wr_data[8*i +: 8];
        bus.mem_rd_data <= mem[bus.mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at a negedge with the DUT idle.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] tag, input int hold);
        int n, k, lat, exp_lat, wr_cnt;
        logic err;
        logic [31:0] v, rd, exp_be;
        n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        k = int'(addr[1:0]);
        err = (we ? f3 > 3'd2 : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (addr % n != 0);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (32'(ref_bytes[8'(addr + i)]) << (8 * i));
        if (!f3[2] && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        exp_lat = err ? 1 : we ? 2 : 3;
        exp_be = ((32'd1 << n) - 1) << k;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_tag = tag;
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_tag = 5'($urandom);
        wr_cnt = 0;
        for (lat = 1; lat < 8; lat++) begin
            if (lat == 1 && !err) chk("mem_addr", bus.mem_addr, addr);
            if (bus.mem_wr_en) begin
                wr_cnt++;
                last_wr_data = bus.mem_wr_data;
                chk("wr_cycle", lat, 1);
                chk("byte_en", 32'(bus.mem_byte_en), exp_be);
                for (int i = 0; i < 4; i++)
                    if (bus.mem_byte_en[i])
                        chk("wr_lane", 32'(bus.mem_wr_data[8*i +: 8]), 32'(8'(wdata >> (8 * (i - k)))));
            end else chk("byte_en_idle", 32'(bus.mem_byte_en), 0);
            if (bus.resp_valid) break;
            @(negedge clk);
        end
        rd = (err || we) ? 32'd0 : v;
        chk("latency", lat, exp_lat);
        chk("resp_valid", 32'(bus.resp_valid), 1);
        chk("wr_count", wr_cnt, (we && !err) ? 1 : 0);
        chk("resp_rdata", bus.resp_rdata, rd);
        chk("resp_tag", 32'(bus.resp_tag), 32'(tag));
        chk("resp_err", 32'(bus.resp_err), 32'(err));
        if (we && !err)
            for (int i = 0; i < n; i++) ref_bytes[8'(addr + i)] = 8'(wdata >> (8 * i));
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 1);
            chk("hold_rdata", bus.resp_rdata, rd);
            chk("hold_tag", 32'(bus.resp_tag), 32'(tag));
            chk("hold_err", 32'(bus.resp_err), 32'(err));
            chk("hold_req_ready", 32'(bus.req_ready), 0);
            chk("hold_wr_en", 32'(bus.mem_wr_en), 0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("post_req_ready", 32'(bus.req_ready), 1);
        chk("post_resp_valid", 32'(bus.resp_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'd0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_tag = 5'd0; bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_tag", 32'(bus.resp_tag), 0);
        chk("rst_resp_err", 32'(bus.resp_err), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rst_byte_en", 32'(bus.mem_byte_en), 0);
        chk("rst_wr_data", bus.mem_wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(1'b1, 3'd0, 32'h103, 32'h000000A5, 5'd1, 0);
        chk("sb_replicate", last_wr_data, 32'hA5A5A5A5);
        do_txn(1'b1, 3'd2, 32'h100, 32'h80FF1234, 5'd2, 0);
        chk("sw_mem_word", mem[0], 32'h80FF1234);
        do_txn(1'b0, 3'd0, 32'h103, 32'h0, 5'd3, 0);
        do_txn(1'b0, 3'd4, 32'h103, 32'h0, 5'd4, 0);
        do_txn(1'b0, 3'd1, 32'h102, 32'h0, 5'd5, 0);
        do_txn(1'b0, 3'd5, 32'h102, 32'h0, 5'd6, 0);
        do_txn(1'b0, 3'd2, 32'h100, 32'h0, 5'd8, 0);
        do_txn(1'b0, 3'd2, 32'h102, 32'h0, 5'd9, 0);
        do_txn(1'b1, 3'd1, 32'h101, 32'hBEEF, 5'd10, 0);
        do_txn(1'b0, 3'd6, 32'h100, 32'h0, 5'd11, 0);
        do_txn(1'b1, 3'd4, 32'h100, 32'h0, 5'd12, 0);
        do_txn(1'b0, 3'd0, 32'h103, 32'h0, 5'd7, 3);
        for (int t = 0; t < 300; t++)
            do_txn(1'($urandom), 3'($urandom), 32'h100 + $urandom_range(0, 255), $urandom,
                   5'($urandom), $urandom_range(0, 2));
        // Reset while a word store sits in ISSUE must suppress the write.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h110; bus.req_wdata = 32'hDEADBEEF; bus.req_tag = 5'd13;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("issue_wr_en", 32'(bus.mem_wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(bus.mem_wr_en), 0);
        chk("arst_byte_en", 32'(bus.mem_byte_en), 0);
        chk("arst_resp_valid", 32'(bus.resp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_mem_word", mem[4], {ref_bytes[8'h13], ref_bytes[8'h12], ref_bytes[8'h11], ref_bytes[8'h10]});
        chk("arst_req_ready", 32'(bus.req_ready), 1);
        chk("arst_resp_valid2", 32'(bus.resp_valid), 0);
        do_txn(1'b0, 3'd2, 32'h110, 32'h0, 5'd14, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
